// File: rtl/time_mem_sched_pkg.sv
// Shared definitions for the time-domain effect blocks.
package time_mem_sched_pkg;

  localparam int unsigned DATA_W_DEF   = 18;
  localparam int unsigned CTRL_EN_BIT  = 7;
  localparam int unsigned CTRL_DLY_MSB = 6;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_MIX   = 3'd4
  } sched_state_t;

endpackage

// File: rtl/time_mem_sched_mix_unit.sv
// Dry/delayed average with bypass and zero-fill, registered onto audio_out.
module time_mix_unit
  import time_mem_sched_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     mix_en,
  input  logic                     enable,
  input  logic                     zero_del,
  input  logic signed [DATA_W-1:0] dry,
  input  logic signed [DATA_W-1:0] del,
  output logic        [DATA_W-1:0] audio_out,
  output logic                     out_valid
);

  logic signed [DATA_W-1:0] del_eff;
  logic signed [DATA_W-1:0] mix_val;

  // Each operand is halved before the add, so the sum cannot overflow.
  always_comb begin
    del_eff = zero_del ? '0 : del;
    mix_val = enable ? ((dry >>> 1) + (del_eff >>> 1)) : dry;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      audio_out <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= mix_en;
      if (mix_en) begin
        audio_out <= mix_val;
      end
    end
  end

endmodule

// File: rtl/time_mem_sched.sv
// Circular delay-line scheduler for the external sample RAM.
module time_mem_sched
  import time_mem_sched_pkg::*;
#(
  parameter int unsigned DATA_W     = DATA_W_DEF,
  parameter int unsigned ADDR_W     = 16,
  parameter int unsigned DLY_SHIFT  = 9,
  parameter int unsigned RD_LATENCY = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              ready,
  input  logic [DATA_W-1:0] audio_in,
  input  logic [7:0]        controls,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_din,
  input  logic [DATA_W-1:0] mem_dout,
  output logic [DATA_W-1:0] audio_out,
  output logic              out_valid,
  output logic              busy,
  output logic              overrun
);

  localparam logic [31:0] ADDR_MAX = 32'((64'd1 << ADDR_W) - 64'd1);

  sched_state_t      state;
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] fill;
  logic [ADDR_W-1:0] dly_q;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] dly_sat;
  logic [31:0]       dly_raw;
  logic [DATA_W-1:0] sample_q;
  logic [DATA_W-1:0] del_q;
  logic              en_q;
  logic [1:0]        wait_cnt;

  always_comb begin
    dly_raw = 32'(controls[CTRL_DLY_MSB:0]) << DLY_SHIFT;
    dly_sat = (dly_raw > ADDR_MAX) ? ADDR_MAX[ADDR_W-1:0] : dly_raw[ADDR_W-1:0];
  end

  // wr_ptr has already advanced past the written slot while in READ.
  always_comb begin
    rd_addr = wr_ptr - ADDR_W'(1) - dly_q;
    busy    = (state != ST_IDLE);
    mem_we  = (state == ST_WRITE);
    mem_din = (state == ST_WRITE) ? sample_q : '0;
    case (state)
      ST_WRITE: mem_addr = wr_ptr;
      ST_READ:  mem_addr = rd_addr;
      default:  mem_addr = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      wr_ptr   <= '0;
      fill     <= '0;
      dly_q    <= '0;
      sample_q <= '0;
      del_q    <= '0;
      en_q     <= 1'b0;
      wait_cnt <= '0;
      overrun  <= 1'b0;
    end else begin
      if (ready && (state != ST_IDLE)) begin
        overrun <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (ready) begin
            sample_q <= audio_in;
            en_q     <= controls[CTRL_EN_BIT];
            dly_q    <= dly_sat;
            state    <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          wr_ptr <= wr_ptr + ADDR_W'(1);
          if (fill != '1) begin
            fill <= fill + ADDR_W'(1);
          end
          state <= ST_READ;
        end
        ST_READ: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (wait_cnt == 2'(RD_LATENCY - 1)) begin
            del_q <= mem_dout;
            state <= ST_MIX;
          end else begin
            wait_cnt <= wait_cnt + 2'd1;
          end
        end
        ST_MIX: begin
          state <= ST_IDLE;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  time_mix_unit #(
    .DATA_W(DATA_W)
  ) u_mix (
    .clock    (clock),
    .reset    (reset),
    .mix_en   (state == ST_MIX),
    .enable   (en_q),
    .zero_del (fill <= dly_q),
    .dry      (sample_q),
    .del      (del_q),
    .audio_out(audio_out),
    .out_valid(out_valid)
  );

endmodule

// File: tb/tb_time_mem_sched.sv
// Scoreboard bench for time_mem_sched with a behavioural RAM and delay-line model.
module tb_time_mem_sched;

  localparam int DW    = 18;
  localparam int AW    = 10;
  localparam int SHIFT = 9;
  localparam int L     = 1;
  localparam int DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          ready = 1'b0;
  logic [DW-1:0] audio_in = '0;
  logic [7:0]    controls = '0;
  logic [AW-1:0] mem_addr;
  logic          mem_we;
  logic [DW-1:0] mem_din;
  logic [DW-1:0] mem_dout;
  logic [DW-1:0] audio_out;
  logic          out_valid;
  logic          busy;
  logic          overrun;

  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;

  typedef struct { int addr; int data; } wr_t;
  typedef struct { int val; longint when; } out_t;

  wr_t  wq[$];
  int   rq[$];
  out_t oq[$];
  int   hist[int];
  int   model_n = 0;

  time_mem_sched #(
    .DATA_W    (DW),
    .ADDR_W    (AW),
    .DLY_SHIFT (SHIFT),
    .RD_LATENCY(L)
  ) dut (
    .clock    (clk),
    .reset    (rst_n),
    .ready    (ready),
    .audio_in (audio_in),
    .controls (controls),
    .mem_addr (mem_addr),
    .mem_we   (mem_we),
    .mem_din  (mem_din),
    .mem_dout (mem_dout),
    .audio_out(audio_out),
    .out_valid(out_valid),
    .busy     (busy),
    .overrun  (overrun)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Sample RAM with L-clock read latency; contents start as garbage.
  logic [DW-1:0] ram [0:DEPTH-1];
  logic [DW-1:0] rd_pipe [0:L-1];
  initial for (int i = 0; i < DEPTH; i++) ram[i] = DW'($urandom);
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_din;
    rd_pipe[0] <= ram[mem_addr];
    for (int i = 1; i < L; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[L-1];

  task automatic check(string name, longint act, longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int half(int v);
    return (v >= 0) ? v / 2 : -((-v + 1) / 2);
  endfunction

  // Reference: sample n lands at n mod DEPTH; the delayed tap is sample n-dly
  // once more than dly samples have been stored.
  task automatic model_accept(int val, logic [7:0] ctl);
    int   dly, fill, del, expv;
    wr_t  w;
    out_t o;
    dly  = int'(ctl[6:0]) << SHIFT;
    if (dly > DEPTH - 1) dly = DEPTH - 1;
    fill = (model_n + 1 < DEPTH - 1) ? model_n + 1 : DEPTH - 1;
    hist[model_n] = val;
    del  = (fill <= dly) ? 0 : hist[model_n - dly];
    expv = ctl[7] ? half(val) + half(del) : val;
    w.addr = model_n % DEPTH;
    w.data = val;
    wq.push_back(w);
    rq.push_back(((model_n - dly) % DEPTH + DEPTH) % DEPTH);
    o.val  = expv;
    o.when = cyc + 4 + L;
    oq.push_back(o);
    model_n++;
  endtask

  task automatic clear_model();
    wq.delete();
    rq.delete();
    oq.delete();
    hist.delete();
    model_n = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    #2;
  endtask

  task automatic send(int val, logic [7:0] ctl, int gap, bit scramble);
    ready    = 1'b1;
    audio_in = val[DW-1:0];
    controls = ctl;
    model_accept(val, ctl);
    tick();
    ready = 1'b0;
    if (scramble) begin
      controls = 8'($urandom);
      audio_in = DW'($urandom);
    end
    repeat (gap) tick();
  endtask

  task automatic do_reset(int n);
    rst_n = 1'b0;
    clear_model();
    repeat (n) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic drain(string ph);
    int t = 0;
    while (oq.size() != 0 && t < 100) begin
      tick();
      t++;
    end
    check({ph, "_drain"}, oq.size(), 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued expectations.
  bit   prev_we = 1'b0;
  wr_t  mw;
  out_t mo;
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      check("rst_ctl", {mem_we, out_valid, busy, overrun}, 0);
      check("rst_addr", mem_addr, 0);
      check("rst_din", mem_din, 0);
      check("rst_out", audio_out, 0);
      prev_we = 1'b0;
    end else begin
      if (mem_we) begin
        check("we_expected", wq.size() > 0, 1);
        if (wq.size() > 0) begin
          mw = wq.pop_front();
          check("wr_addr", mem_addr, mw.addr);
          check("wr_data", $signed(mem_din), mw.data);
        end
        prev_we = 1'b1;
      end else if (prev_we) begin
        prev_we = 1'b0;
        check("rd_expected", rq.size() > 0, 1);
        if (rq.size() > 0) check("rd_addr", mem_addr, rq.pop_front());
      end
      if (out_valid) begin
        check("valid_expected", oq.size() > 0, 1);
        if (oq.size() > 0) begin
          mo = oq.pop_front();
          check("audio_out", $signed(audio_out), mo.val);
          check("latency", cyc, mo.when);
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1);
  end

  initial begin
    int ph;
    int code;
    logic [7:0] ctl;

    // Reset held with ready toggling.
    rst_n = 1'b0;
    repeat (8) begin
      ready    = ~ready;
      audio_in = DW'($urandom);
      controls = 8'($urandom);
      tick();
    end
    ready = 1'b0;
    rst_n = 1'b1;
    tick();
    check("busy_after_reset", busy, 0);
    check("overrun_after_reset", overrun, 0);

    // Bypass.
    send(32'h01234, 8'h00, 6, 1'b0);
    drain("bypass");

    // Delay average, positive then negative.
    repeat (600) send(1000, 8'h81, $urandom_range(4, 12), 1'b1);
    drain("avg_pos");
    do_reset(2);
    repeat (520) send(-1000, 8'h81, $urandom_range(4, 12), 1'b1);
    drain("avg_neg");

    // Random samples/controls across the pointer wrap.
    do_reset(2);
    for (int i = 0; i < 1100; i++) begin
      code = $urandom_range(0, 3);
      ctl[7]   = 1'($urandom);
      ctl[6:0] = (code == 3) ? 7'($urandom) : 7'(code);
      send(int'($urandom_range(0, 262143)) - 131072, ctl, $urandom_range(4, 8), 1'b1);
    end
    drain("wrap");
    check("no_overrun_random", overrun, 0);

    // Second ready two clocks after the first.
    do_reset(2);
    send(111, 8'h00, 1, 1'b0);
    ready = 1'b1;
    audio_in = DW'(999);
    tick();
    ready = 1'b0;
    repeat (8) tick();
    drain("overrun");
    check("overrun_set", overrun, 1);
    repeat (20) tick();
    check("overrun_sticky", overrun, 1);

    // Ready in the MIX cycle is dropped; the next cycle is accepted.
    do_reset(2);
    check("overrun_cleared", overrun, 0);
    send(200, 8'h80, 3, 1'b0);
    ready = 1'b1;
    audio_in = DW'(555);
    tick();
    send(300, 8'h80, 6, 1'b0);
    drain("mix_drop");
    check("overrun_mix_drop", overrun, 1);

    // Reset during WRITE, then during WAIT.
    for (int k = 0; k < 2; k++) begin
      ph = (k == 0) ? 1 : 3;
      do_reset(2);
      ready    = 1'b1;
      audio_in = DW'(777);
      controls = 8'h81;
      model_accept(777, 8'h81);
      tick();
      ready = 1'b0;
      repeat (ph - 1) tick();
      rst_n = 1'b0;
      #1;
      check("we_async_drop", mem_we, 0);
      check("busy_async_drop", busy, 0);
      clear_model();
      repeat (3) tick();
      rst_n = 1'b1;
      repeat (10) tick();
      send(4321, 8'h81, 6, 1'b0);
      drain("reset_midop");
    end

    check("wq_empty", wq.size(), 0);
    check("rq_empty", rq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
